led_pattern_player: RTL

- Synthesizable LED pattern sequencer.
- Holds a small writable table of LED words and plays it out on the LED bus, one entry per prescaler period.
- Supports one-shot and looping playback.
- Sits between the board-level control logic (load/start/stop) and the LED pins.
- Its output stream is the sequence the LED self-checking bench compares, entry by entry, against the expected pattern file.

---
 rtl/led_pattern_player_pkg.sv | 13 +
 rtl/led_pattern_player_if.sv | 29 ++
 rtl/led_pattern_player_pattern_ram.sv | 26 ++
 rtl/led_pattern_player.sv | 125 ++++++++++++
 4 files changed

// File: rtl/led_pattern_player_pkg.sv
// Shared constants and state encoding for the LED pattern player and its bench.
package led_pattern_player_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 5;
  localparam int unsigned DEFAULT_DEPTH  = 8;
  localparam int unsigned DEFAULT_ADDR_W = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/led_pattern_player_if.sv
// Control/table-load/LED bundle between board control logic and the pattern player.
interface led_pattern_player_if #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned ADDR_W = 3
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] last_addr;
  logic              loop;
  logic              start;
  logic              stop;
  logic [WIDTH-1:0]  led;
  logic [ADDR_W-1:0] index;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, last_addr, loop, start, stop,
    input  led, index, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, last_addr, loop, start, stop,
    output led, index, busy, done
  );

endinterface

// File: rtl/led_pattern_player_pattern_ram.sv
// Pattern table: one write port, one combinational read port, contents not reset.
module pattern_ram #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Out-of-range write addresses are dropped rather than aliased.
  always_ff @(posedge clock) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/led_pattern_player.sv
// LED pattern sequencer: plays table entries on the LED bus, one per DIV-cycle period,
// in one-shot or looping mode.
module led_pattern_player
  import led_pattern_player_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DIV    = 50000000
) (
  input logic                 clock,
  input logic                 reset,
  led_pattern_player_if.slave bus
);

  localparam int unsigned       CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(DEPTH - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] index_q, index_n;
  logic [ADDR_W-1:0] last_r, last_n;
  logic              loop_r, loop_n;
  logic [WIDTH-1:0]  led_q, led_n;
  logic              done_q, done_n;
  logic [WIDTH-1:0]  rd_data;
  logic [ADDR_W-1:0] last_clamped;
  logic              cnt_end;

  pattern_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock  (clock),
    .wr_en  (bus.wr_en),
    .wr_addr(bus.wr_addr),
    .wr_data(bus.wr_data),
    .rd_addr(index_n),
    .rd_data(rd_data)
  );

  assign last_clamped = (32'(bus.last_addr) >= DEPTH) ? LAST_MAX : bus.last_addr;
  assign cnt_end      = (cnt == CNT_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      index_q <= '0;
      last_r  <= '0;
      loop_r  <= 1'b0;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      index_q <= index_n;
      last_r  <= last_n;
      loop_r  <= loop_n;
      led_q   <= led_n;
      done_q  <= done_n;
    end
  end

  // Completion is evaluated before a same-edge restart so done still pulses.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    index_n = index_q;
    last_n  = last_r;
    loop_n  = loop_r;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_n = S_RUN;
          cnt_n   = '0;
          index_n = '0;
          last_n  = last_clamped;
          loop_n  = bus.loop;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          index_n = '0;
        end else begin
          if (cnt_end && (index_q == last_r) && !loop_r) begin
            done_n = 1'b1;
          end
          if (bus.start) begin
            cnt_n   = '0;
            index_n = '0;
            last_n  = last_clamped;
            loop_n  = bus.loop;
          end else if (!cnt_end) begin
            cnt_n = cnt + 1'b1;
          end else begin
            cnt_n = '0;
            if (index_q != last_r) begin
              index_n = index_q + 1'b1;
            end else if (loop_r) begin
              index_n = '0;
            end else begin
              state_n = S_IDLE;
              index_n = '0;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign led_n = (state_n == S_RUN) ? rd_data : '0;

  assign bus.led   = led_q;
  assign bus.index = index_q;
  assign bus.busy  = (state == S_RUN);
  assign bus.done  = done_q;

endmodule
